// File: rtl/core_writeback_pkg.sv
// Shared micro-architecture types for the writeback stage: register numbers,
// writeback lines and queue entries.
package core_writeback_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned REG_BITS      = 4;
  localparam int unsigned NUM_REGS      = 2 ** REG_BITS;
  localparam int unsigned WB_FIFO_DEPTH = 2;

  typedef logic [REG_BITS-1:0] reg_num;

  typedef struct packed {
    reg_num              rd;
    logic [DATA_W-1:0]   value;
    logic                ready;
  } wb_line;

  typedef struct packed {
    reg_num              rd;
    logic [DATA_W-1:0]   value;
  } wb_entry;

  function automatic logic [NUM_REGS-1:0] reg_mask(input reg_num r);
    reg_mask    = '0;
    reg_mask[r] = 1'b1;
  endfunction

endpackage

// File: rtl/core_wb_fifo.sv
// In-order holding queue for ALU results awaiting the register-file write port.
module core_wb_fifo
  import core_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry                      push_data,
  input  logic                         pop,
  output wb_entry                      pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry          r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rptr];

  // A pop in the same cycle frees the slot, so a push into a full queue is legal then.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/core_writeback.sv
// Writeback arbiter: loads always win the single register-file write port,
// ALU results queue behind them in order; tracks in-flight destinations.
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int unsigned W          = DATA_W,
  parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  wb_line                alu_wb,
  input  wb_line                mem_wb,
  input  logic                  issue_valid,
  input  reg_num                issue_rd,
  output logic                  rf_we,
  output reg_num                rf_waddr,
  output logic [W-1:0]          rf_wdata,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  alu_stall
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  wb_entry               w_alu_entry;
  wb_entry               w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic                  w_we;
  reg_num                w_waddr;
  logic [DATA_W-1:0]     w_wdata;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_set;

  logic                  r_rf_we;
  reg_num                r_rf_waddr;
  logic [W-1:0]          r_rf_wdata;
  logic [NUM_REGS-1:0]   r_busy;

  assign w_alu_entry = '{rd: alu_wb.rd, value: alu_wb.value};

  core_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_alu_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // ALU results go straight to the port only when nothing older is waiting.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_pop   = 1'b0;
    w_push  = alu_wb.ready && (mem_wb.ready || !w_empty);
    if (mem_wb.ready) begin
      w_we    = 1'b1;
      w_waddr = mem_wb.rd;
      w_wdata = mem_wb.value;
    end else if (!w_empty) begin
      w_we    = 1'b1;
      w_waddr = w_head.rd;
      w_wdata = w_head.value;
      w_pop   = 1'b1;
    end else if (alu_wb.ready) begin
      w_we    = 1'b1;
      w_waddr = alu_wb.rd;
      w_wdata = alu_wb.value;
    end
  end

  assign w_clr = w_we        ? reg_mask(w_waddr)  : '0;
  assign w_set = issue_valid ? reg_mask(issue_rd) : '0;

  assign alu_stall = !rst && (w_full ||
                     ((w_count == CW'(FIFO_DEPTH - 1)) && mem_wb.ready && alu_wb.ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_busy     <= '0;
    end else begin
      r_rf_we    <= w_we;
      r_rf_waddr <= w_waddr;
      r_rf_wdata <= W'(w_wdata);
      // Set after clear: a newer producer keeps the register pending.
      r_busy     <= (r_busy & ~w_clr) | w_set;
    end
  end

  a_alu_overflow: assert property (@(posedge clk) disable iff (rst)
    !(alu_wb.ready && w_full && !w_pop));

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_core_writeback.sv
// Scoreboard bench for core_writeback: a reference model predicts each cycle's
// write, scoreboard and stall; expectations are queued at drive time.
module tb_core_writeback;
  import core_writeback_pkg::*;

  localparam int unsigned D = WB_FIFO_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst;
  wb_line                alu_wb;
  wb_line                mem_wb;
  logic                  issue_valid;
  reg_num                issue_rd;
  logic                  rf_we;
  reg_num                rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [NUM_REGS-1:0]   busy;
  logic                  alu_stall;

  always #5 clk = ~clk;

  core_writeback #(
    .W          (DATA_W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_wb      (alu_wb),
    .mem_wb      (mem_wb),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .alu_stall   (alu_stall)
  );

  typedef struct {
    logic                 we;
    reg_num               addr;
    logic [DATA_W-1:0]    data;
    logic [NUM_REGS-1:0]  bsy;
    logic                 rst_cyc;
  } exp_t;

  exp_t                exp_q[$];
  wb_entry             m_q[$];
  logic [NUM_REGS-1:0] m_busy;
  int unsigned         n_checks;
  int unsigned         n_errors;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic mr, input reg_num mrd, input logic [DATA_W-1:0] mv,
                      input logic ar, input reg_num ard, input logic [DATA_W-1:0] av,
                      input logic iv, input reg_num ird);
    exp_t    e;
    wb_entry w;
    logic    wv;
    logic    exp_stall;
    @(negedge clk);
    rst         = r;
    mem_wb      = '{rd: mrd, value: mv, ready: mr};
    alu_wb      = '{rd: ard, value: av, ready: ar};
    issue_valid = iv;
    issue_rd    = ird;
    exp_stall   = !r && ((m_q.size() == D) || (m_q.size() == D - 1 && mr && ar));
    #1;
    check("alu_stall", 32'(alu_stall), 32'(exp_stall));
    wv = 1'b0;
    w  = '0;
    if (r) begin
      m_q.delete();
      m_busy = '0;
    end else begin
      if (mr) begin
        wv = 1'b1;
        w  = '{rd: mrd, value: mv};
        if (ar && m_q.size() < D) m_q.push_back('{rd: ard, value: av});
      end else if (m_q.size() != 0) begin
        wv = 1'b1;
        w  = m_q.pop_front();
        if (ar) m_q.push_back('{rd: ard, value: av});
      end else if (ar) begin
        wv = 1'b1;
        w  = '{rd: ard, value: av};
      end
      if (wv) m_busy[w.rd] = 1'b0;
      if (iv) m_busy[ird]  = 1'b1;
    end
    exp_q.push_back('{we: wv, addr: w.rd, data: w.value, bsy: m_busy, rst_cyc: r});

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", 32'(rf_we), 32'(e.we));
    if (e.we || e.rst_cyc) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
      check("rf_wdata", 32'(rf_wdata), 32'(e.data));
    end
    check("busy", 32'(busy), 32'(e.bsy));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_busy      = '0;
    rst         = 1'b1;
    mem_wb      = '0;
    alu_wb      = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;

    step(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd9, 16'hFFFF, 1'b1, 4'd8, 16'hEEEE, 1'b1, 4'd2);

    // ALU only, with r3 previously marked busy
    step(1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b1, 4'd3);
    step(1'b0, 1'b0, 4'd0, '0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0);
    idle();

    // Load/ALU collision
    step(1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'h5555, 1'b0, 4'd0);
    idle();
    idle();

    // Fill the queue behind four back-to-back loads, then drain
    step(1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd10, 16'hA0A0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd11, 16'hB0B0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, '0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd12, 16'hCCCC, 1'b0, 4'd0, '0, 1'b0, 4'd0);
    idle();
    idle();
    idle();

    // Scoreboard set/clear race on r7
    step(1'b0, 1'b0, 4'd0, '0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7);
    step(1'b0, 1'b0, 4'd0, '0, 1'b1, 4'd7, 16'h7070, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b1, 4'd7);
    idle();

    // Reset with two entries queued: nothing queued may ever be written
    step(1'b0, 1'b1, 4'd13, 16'hD1D1, 1'b1, 4'd14, 16'hE1E1, 1'b1, 4'd14);
    step(1'b0, 1'b1, 4'd13, 16'hD2D2, 1'b1, 4'd15, 16'hF1F1, 1'b1, 4'd15);
    step(1'b1, 1'b1, 4'd1, 16'h0BAD, 1'b1, 4'd2, 16'h0BAD, 1'b1, 4'd3);
    idle();
    idle();
    idle();

    // Random traffic; ALU results are withheld only where they would be dropped
    for (int i = 0; i < 400; i++) begin
      logic   r, mr, ar, iv;
      r  = ($urandom_range(0, 49) == 0);
      mr = ($urandom_range(0, 2) == 0);
      ar = ($urandom_range(0, 1) == 1) && !(m_q.size() == D && mr);
      iv = ($urandom_range(0, 1) == 1);
      step(r, mr, reg_num'($urandom_range(0, 15)), DATA_W'($urandom),
           ar, reg_num'($urandom_range(0, 15)), DATA_W'($urandom),
           iv, reg_num'($urandom_range(0, 15)));
    end
    idle();
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
